vga_pattern_check: RTL

Sink-side checker for the 16-bar VGA test pattern. It sits on the pixel bus next to the timing generator and consumes `rgb_*` plus the active flags. It rebuilds the expected bar colour for every active pixel and counts mismatches. It also measures active line length and frame height, and reports a per-frame pass/fail, which lets the pattern path be checked in hardware or simulation without a monitor.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_bar_ref.sv | 52 +++++
 rtl/vga_pattern_check.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// ============================================================================
// vga_pkg : colour table, bar count and checker state encoding shared by the
//           VGA pattern generator and checker.
// Revision : 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int VGA_NUM_BARS  = 16;
    localparam int VGA_BAR_IDX_W = 4;

    // Index 0 sits in the least-significant slot: FFF, CCC, 888, 000, ...
    localparam logic [VGA_NUM_BARS-1:0][11:0] VGA_COLOUR_TABLE = {
        12'h808, 12'hF0F, 12'h008, 12'h00F,
        12'h088, 12'h0FF, 12'h080, 12'h0F0,
        12'h880, 12'hFF0, 12'h800, 12'hF00,
        12'h000, 12'h888, 12'hCCC, 12'hFFF
    };

    typedef enum logic [1:0] {
        ACQUIRE  = 2'd0,
        ARMED    = 2'd1,
        CHECKING = 2'd2
    } vga_state_e;

    function automatic logic [11:0] vga_bar_colour(input logic [VGA_BAR_IDX_W-1:0] idx);
        return VGA_COLOUR_TABLE[idx];
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_bar_ref.sv
// ============================================================================
// vga_bar_ref : tracks column within the current bar and emits the colour
//               the current valid pixel must have.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_bar_ref
    import vga_pkg::*;
(
    input  logic        pxl_clk_i,
    input  logic        pxl_rst_n_i,
    input  logic        valid_i,
    input  logic [31:0] bar_width_i,
    output logic [11:0] exp_rgb_o
);

    logic [31:0]              pos_cnt_q, pos_cnt_d;
    logic [VGA_BAR_IDX_W-1:0] bar_idx_q, bar_idx_d;

    // A zero bar width pins every pixel to bar 0.
    always_comb begin
        pos_cnt_d = pos_cnt_q;
        bar_idx_d = bar_idx_q;
        if (!valid_i) begin
            pos_cnt_d = '0;
            bar_idx_d = '0;
        end else if (bar_width_i != 32'd0) begin
            if (pos_cnt_q == bar_width_i - 32'd1) begin
                pos_cnt_d = '0;
                bar_idx_d = bar_idx_q + 1'b1;
            end else begin
                pos_cnt_d = pos_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge pxl_clk_i) begin
        if (!pxl_rst_n_i) begin
            pos_cnt_q <= '0;
            bar_idx_q <= '0;
        end else begin
            pos_cnt_q <= pos_cnt_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    assign exp_rgb_o = vga_bar_colour(bar_idx_q);

endmodule

`default_nettype wire

// File: rtl/vga_pattern_check.sv
// ============================================================================
// vga_pattern_check : sink-side checker for the 16-bar VGA test pattern.
//                     Optional first-error capture: VGA_CHECK_CAPTURE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_pattern_check
    import vga_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 pxl_clk,
    input  logic                 pxl_rst_n,
    input  logic [31:0]          horz_res,
    input  logic [31:0]          vert_res,
    input  logic                 horz_active,
    input  logic                 vert_active,
    input  logic                 frame_active,
    input  logic [3:0]           rgb_red,
    input  logic [3:0]           rgb_green,
    input  logic [3:0]           rgb_blue,
    output logic                 armed,
    output logic                 frame_done,
    output logic                 frame_ok,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 geom_err
`ifdef VGA_CHECK_CAPTURE_EN
    ,
    output logic [31:0]          err_x,
    output logic [31:0]          err_y,
    output logic [11:0]          err_rgb
`endif
);

    vga_state_e           state_q;
    logic                 armed_q, fa_q, ha_q, va_q;
    logic                 mismatch_q, len_err_q, hgt_err_q;
    logic                 vfall_q, vfall2_q, frame_err_q, frame_done_q, frame_ok_q, geom_q;
    logic [31:0]          line_len_q, line_len_d, line_cnt_q, line_cnt_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic        w_live, w_checking, w_valid, w_mis;
    logic        w_fa_fall, w_ha_fall, w_va_fall;
    logic [11:0] w_pix, w_exp;

    // The rising edge of vert_active already belongs to the frame being checked.
    assign w_checking = (state_q == CHECKING);
    assign w_live     = w_checking | ((state_q == ARMED) & vert_active);
    assign w_valid    = w_live & frame_active;
    assign w_fa_fall  = fa_q & ~frame_active;
    assign w_ha_fall  = ha_q & ~horz_active;
    assign w_va_fall  = va_q & ~vert_active;
    assign w_pix      = {rgb_red, rgb_green, rgb_blue};
    assign w_mis      = w_valid & (w_pix != w_exp);

    vga_bar_ref u_bar_ref (
        .pxl_clk_i   (pxl_clk),
        .pxl_rst_n_i (pxl_rst_n),
        .valid_i     (w_valid),
        .bar_width_i (horz_res >> 4),
        .exp_rgb_o   (w_exp)
    );

    always_comb begin
        line_len_d = line_len_q;
        if (w_fa_fall) begin
            line_len_d = '0;
        end else if (w_valid) begin
            line_len_d = line_len_q + 32'd1;
        end

        line_cnt_d = line_cnt_q;
        if (w_checking & w_va_fall) begin
            line_cnt_d = '0;
        end else if (w_checking & w_ha_fall & vert_active) begin
            line_cnt_d = line_cnt_q + 32'd1;
        end

        err_cnt_d = err_cnt_q;
        if (mismatch_q && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pxl_clk) begin
        if (!pxl_rst_n) begin
            state_q      <= ACQUIRE;
            armed_q      <= 1'b0;
            fa_q         <= 1'b0;
            ha_q         <= 1'b0;
            va_q         <= 1'b0;
            mismatch_q   <= 1'b0;
            len_err_q    <= 1'b0;
            hgt_err_q    <= 1'b0;
            vfall_q      <= 1'b0;
            vfall2_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            geom_q       <= 1'b0;
            line_len_q   <= '0;
            line_cnt_q   <= '0;
            err_cnt_q    <= '0;
        end else begin
            case (state_q)
                ACQUIRE: begin
                    if (!vert_active) begin
                        state_q <= ARMED;
                        armed_q <= 1'b1;
                    end
                end
                ARMED: begin
                    if (vert_active) begin
                        state_q <= CHECKING;
                    end
                end
                CHECKING: state_q <= CHECKING;
                default:  state_q <= ACQUIRE;
            endcase

            fa_q       <= frame_active;
            ha_q       <= horz_active;
            va_q       <= vert_active;
            mismatch_q <= w_mis;
            len_err_q  <= w_checking & w_fa_fall & (line_len_q != horz_res);
            hgt_err_q  <= w_checking & w_va_fall & (line_cnt_q != vert_res);
            line_len_q <= line_len_d;
            line_cnt_q <= line_cnt_d;
            err_cnt_q  <= err_cnt_d;
            geom_q     <= geom_q | len_err_q | hgt_err_q;

            // Two-stage delay lets the last line's length verdict land first.
            vfall_q      <= w_checking & w_va_fall;
            vfall2_q     <= vfall_q;
            frame_done_q <= vfall2_q;
            if (vfall2_q) begin
                frame_ok_q <= ~frame_err_q;
            end
            frame_err_q <= (vfall2_q ? 1'b0 : frame_err_q) | mismatch_q | len_err_q | hgt_err_q;
        end
    end

    assign armed      = armed_q;
    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign err_cnt    = err_cnt_q;
    assign geom_err   = geom_q;

`ifdef VGA_CHECK_CAPTURE_EN
    logic        cap_done_q;
    logic [31:0] err_x_q, err_y_q;
    logic [11:0] err_rgb_q;

    always_ff @(posedge pxl_clk) begin
        if (!pxl_rst_n) begin
            cap_done_q <= 1'b0;
            err_x_q    <= '0;
            err_y_q    <= '0;
            err_rgb_q  <= '0;
        end else if (w_mis && !cap_done_q) begin
            cap_done_q <= 1'b1;
            err_x_q    <= line_len_q;
            err_y_q    <= line_cnt_q;
            err_rgb_q  <= w_pix;
        end
    end

    assign err_x   = err_x_q;
    assign err_y   = err_y_q;
    assign err_rgb = err_rgb_q;
`endif

endmodule

`default_nettype wire
